// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: BasicTypes package with register-file write types and queue depth
package BasicTypes;
   localparam int WB_QUEUE_DEPTH = 2;
   typedef logic [31:0] PC;
   typedef logic [4:0]  RegAddr;
   typedef logic [31:0] BasicData;
   typedef struct packed {
      logic     we;
      RegAddr   addr;
      BasicData data;
   } RDCtrl;
   typedef struct packed {
      PC        pc;
      logic     we;
      RegAddr   addr;
      BasicData data;
   } WbEntry;
endpackage

// File: rtl/writeback_queue.sv
// writeback_queue: 2-entry FIFO of retiring instructions; storage itself is not reset
module writeback_queue
   import BasicTypes::*;
#(
   parameter int DEPTH = WB_QUEUE_DEPTH
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_push,
   input  logic   i_pop,
   input  logic   i_clear,
   input  WbEntry i_data,
   output logic   o_full,
   output logic   o_empty,
   output WbEntry o_head
);
   logic [1:0] r_count;
   logic       r_wptr;
   logic       r_rptr;
   WbEntry     r_mem [DEPTH];
   // pointers and occupancy; clear empties the queue and overrides push/pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
      end else if (i_clear) begin
         r_count <= '0;
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
      end else begin
         r_wptr  <= r_wptr ^ i_push;
         r_rptr  <= r_rptr ^ i_pop;
         r_count <= r_count + 2'(i_push) - 2'(i_pop);
      end
   end
   // entry storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end
   assign o_full  = (r_count == 2'(DEPTH));
   assign o_empty = (r_count == 2'd0);
   assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: queues retiring instructions and writes them to the register file; WB_RETIRE_COUNT_EN adds a retire counter
module writeback_stage
   import BasicTypes::*;
#(
   parameter int QUEUE_DEPTH = WB_QUEUE_DEPTH
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        memValid,
   output logic        memReady,
   input  PC           memPc,
   input  logic        memRdWe,
   input  RegAddr      memRdAddr,
   input  BasicData    memRdData,
   input  logic        stall,
   input  logic        flush,
   output PC           rfPc,
   output RDCtrl       rfRdCtrl
`ifdef WB_RETIRE_COUNT_EN
   ,
   output logic [63:0] retireCount
`endif
);
   logic   w_full;
   logic   w_empty;
   logic   w_push;
   logic   w_drain;
   WbEntry w_head;
   // ready depends only on occupancy so a full queue never turns ready through a same-cycle drain
   assign memReady = rst && !w_full;
   // handshake, drain decision and register-file outputs; x0 writes are popped but not written
   always_comb begin
      w_push        = memValid && memReady && !flush;
      w_drain       = !w_empty && !stall && !flush;
      rfRdCtrl.we   = w_drain && w_head.we && (w_head.addr != '0);
      rfRdCtrl.addr = w_empty ? '0 : w_head.addr;
      rfRdCtrl.data = w_empty ? '0 : w_head.data;
      rfPc          = w_drain ? w_head.pc : '0;
   end
   writeback_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_drain),
      .i_clear (flush),
      .i_data  ('{pc: memPc, we: memRdWe, addr: memRdAddr, data: memRdData}),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );
`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] r_retire;
   // every drained entry counts as retired, including suppressed writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_retire <= '0;
      else      r_retire <= r_retire + 64'(w_drain);
   end
   assign retireCount = r_retire;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus with a scoreboard of expected register-file writes
module tb_writeback_stage;
   import BasicTypes::*;
   typedef struct packed {
      PC     pc;
      RDCtrl rd;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        memValid = 1'b0;
   logic        memReady;
   PC           memPc = '0;
   logic        memRdWe = 1'b0;
   RegAddr      memRdAddr = '0;
   BasicData    memRdData = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   PC           rfPc;
   RDCtrl       rfRdCtrl;
   int          n_tests = 0;
   int          n_fail = 0;
   exp_t        sb[$];
`ifdef WB_RETIRE_COUNT_EN
   logic [63:0] retireCount;
   logic [63:0] rc_before;
`endif

   writeback_stage dut (
      .clk       (clk),
      .rst       (rst),
      .memValid  (memValid),
      .memReady  (memReady),
      .memPc     (memPc),
      .memRdWe   (memRdWe),
      .memRdAddr (memRdAddr),
      .memRdData (memRdData),
      .stall     (stall),
      .flush     (flush),
      .rfPc      (rfPc),
      .rfRdCtrl  (rfRdCtrl)
`ifdef WB_RETIRE_COUNT_EN
      ,
      .retireCount (retireCount)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // drive one cycle of inputs just after the rising edge; expected retirements go to the scoreboard
   task automatic drive(input logic v, input PC pc, input logic we, input RegAddr a,
                        input BasicData d, input logic s, input logic f, input logic retire);
      @(posedge clk);
      #1;
      memValid = v; memPc = pc; memRdWe = we; memRdAddr = a; memRdData = d;
      stall = s; flush = f;
      if (retire) sb.push_back('{pc: pc, rd: '{we: we && (a != 5'd0), addr: a, data: d}});
      #1;
   endtask

   task automatic idle(input logic s);
      drive(1'b0, '0, 1'b0, '0, '0, s, 1'b0, 1'b0);
   endtask

   // monitor: every presented write (nonzero rfPc) must match the scoreboard head in order
   always @(negedge clk) begin
      if (rst) begin
         if (rfPc != '0) begin
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got pc 0x%0h rd 0x%0h expected no write", rfPc, rfRdCtrl);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({rfPc, rfRdCtrl} !== e) begin
                  n_fail++;
                  $display("FAIL write: got pc 0x%0h rd 0x%0h expected pc 0x%0h rd 0x%0h",
                           rfPc, rfRdCtrl, e.pc, e.rd);
               end
            end
         end else if (rfRdCtrl.we) begin
            n_tests++;
            n_fail++;
            $display("FAIL stray_we: got we 1 with rfPc 0 expected we 0");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #3;
      chk("rst_ready", 64'(memReady), 64'd0);
      chk("rst_rd", 64'(rfRdCtrl), 64'd0);
      chk("rst_pc", 64'(rfPc), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("post_rst_ready", 64'(memReady), 64'd1);
`ifdef WB_RETIRE_COUNT_EN
      chk("rst_retire", retireCount, 64'd0);
`endif
      // single retire with one-cycle latency
      drive(1'b1, 32'h100, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      chk("t1_pc", 64'(rfPc), 64'h100);
      chk("t1_rd", 64'(rfRdCtrl), {26'd0, 1'b1, 5'd5, 32'hDEADBEEF});
      idle(1'b0);
      chk("t1_empty_pc", 64'(rfPc), 64'd0);
      chk("t1_empty_rd", 64'(rfRdCtrl), 64'd0);
      // x0 destination: popped, not written
`ifdef WB_RETIRE_COUNT_EN
      rc_before = retireCount;
`endif
      drive(1'b1, 32'h104, 1'b1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      chk("t2_we", 64'(rfRdCtrl.we), 64'd0);
      chk("t2_pc", 64'(rfPc), 64'h104);
      idle(1'b0);
      chk("t2_empty", 64'(rfRdCtrl), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
      chk("t2_retire", retireCount, rc_before + 64'd1);
`endif
      // backpressure under stall
      drive(1'b1, 32'h200, 1'b1, 5'd6, 32'hA, 1'b1, 1'b0, 1'b1);
      chk("t3_ready1", 64'(memReady), 64'd1);
      drive(1'b1, 32'h204, 1'b1, 5'd7, 32'hB, 1'b1, 1'b0, 1'b1);
      idle(1'b1);
      chk("t3_full_ready", 64'(memReady), 64'd0);
      chk("t3_stall_pc", 64'(rfPc), 64'd0);
      chk("t3_stall_head", 64'(rfRdCtrl), {26'd0, 1'b0, 5'd6, 32'hA});
      idle(1'b0);
      chk("t3_drain1_pc", 64'(rfPc), 64'h200);
      chk("t3_drain1_ready", 64'(memReady), 64'd0);
      idle(1'b0);
      chk("t3_drain2_pc", 64'(rfPc), 64'h204);
      chk("t3_drain2_ready", 64'(memReady), 64'd1);
      idle(1'b0);
      chk("t3_done_pc", 64'(rfPc), 64'd0);
      // flush with a full queue and a simultaneous offer
      drive(1'b1, 32'h2F0, 1'b1, 5'd8, 32'hC, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h2F4, 1'b1, 5'd9, 32'hD, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h300, 1'b1, 5'd10, 32'hE, 1'b1, 1'b1, 1'b0);
      chk("t4_flush_we", 64'(rfRdCtrl.we), 64'd0);
      chk("t4_flush_pc", 64'(rfPc), 64'd0);
      idle(1'b0);
      chk("t4_after_ready", 64'(memReady), 64'd1);
      chk("t4_after_rd", 64'(rfRdCtrl), 64'd0);
      repeat (3) idle(1'b0);
      // asynchronous reset with two queued entries
      drive(1'b1, 32'h310, 1'b1, 5'd11, 32'hF, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 32'h314, 1'b1, 5'd12, 32'h10, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      chk("t5_full_ready", 64'(memReady), 64'd0);
      #1 rst = 1'b0;
      #1;
      chk("t5_rst_ready", 64'(memReady), 64'd0);
      chk("t5_rst_rd", 64'(rfRdCtrl), 64'd0);
      chk("t5_rst_pc", 64'(rfPc), 64'd0);
`ifdef WB_RETIRE_COUNT_EN
      chk("t5_rst_retire", retireCount, 64'd0);
`endif
      stall = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk("t5_rel_ready", 64'(memReady), 64'd1);
      chk("t5_rel_rd", 64'(rfRdCtrl), 64'd0);
      repeat (3) idle(1'b0);
      // streaming: one accept and one write per cycle, occupancy never reaches 2
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h400 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h1111_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
         chk("t6_ready", 64'(memReady), 64'd1);
         if (i > 0) chk("t6_pc", 64'(rfPc), 64'h400 + 64'(4 * (i - 1)));
      end
      idle(1'b0);
      chk("t6_last_pc", 64'(rfPc), 64'h424);
      repeat (3) idle(1'b0);
`ifdef WB_RETIRE_COUNT_EN
      chk("t6_retire", retireCount, 64'd10);
`endif
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter: QUEUE_DEPTH, 2, writeback queue entry count; only the value 2 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: memValid  input  1  memory stage offers one retiring instruction.
REQ-005 Port: memReady  output  1  stage can accept the offer.
REQ-006 Port: memPc / memRdWe / memRdAddr / memRdData  input  32/1/5/32  retiring PC, write-enable, destination register, result.
REQ-007 Port: stall  input  1  Controller holds writeback; no drain this cycle.
REQ-008 Port: flush  input  1  discard all queued and incoming entries.
REQ-009 Port: rfPc  output  32  PC of the entry written this cycle; 0 when none.
REQ-010 Port: rfRdCtrl  output  RDCtrl (1+5+32)  write-enable, address and data to the register file.
REQ-011 Port: retireCount  output  64  retired-instruction count; present only under WB_RETIRE_COUNT_EN.

Function
REQ-012 Queue: 2-entry FIFO of {pc, we, addr, data}; count range 0..2; pointers wrap modulo 2.
REQ-013 Accept: memValid && memReady && !flush pushes the offer at the clock edge.
REQ-014 memReady = (count < 2); a drain in the same cycle does not make a full queue ready (no combinational ready-to-drain path).
REQ-015 Drain: count > 0 && !stall && !flush pops the head at the clock edge; one entry per cycle maximum.
REQ-016 rfRdCtrl.we = drain && head.we && head.addr != 0; x0 writes are suppressed, but the entry is still popped and retired.
REQ-017 rfRdCtrl.addr/data = head fields when count > 0, otherwise 0; rfPc = head.pc on drain, otherwise 0.
REQ-018 Latency: an entry pushed into an empty queue is written to the register file in the next cycle, provided stall and flush are low.
REQ-019 Simultaneous push and drain: count is unchanged and FIFO order is preserved.
REQ-020 stall holds the entire queue content; pushes continue while count < 2.
REQ-021 flush: count becomes 0 at the edge; the same-cycle push is dropped; rfRdCtrl.we = 0 in the flush cycle; flush takes priority over stall.

Reset
REQ-022 While rst = 0: count = 0, pointers = 0, memReady = 0, rfRdCtrl = 0, rfPc = 0, retireCount = 0; entry storage is not reset.
REQ-023 In the first cycle after rst deasserts: memReady = 1.
REQ-024 Asserting reset mid-operation discards queued entries immediately (asynchronously), with no register file write.

Configuration
REQ-025 With `WB_RETIRE_COUNT_EN` defined: retireCount increments by 1 on every drain (including x0 and we = 0 entries) and wraps at 2^64.
REQ-026 With the macro undefined: the retireCount port and its counter are absent; all other behaviour is identical.

Structure
REQ-027 BasicTypes package holds PC, RegAddr, BasicData, RDCtrl and the constant WB_QUEUE_DEPTH = 2; no types are defined locally.
REQ-028 The FIFO is implemented as sub-module writeback_queue (push/pop/full/empty/head); the top level holds the control, x0 suppression and the optional counter.

Verification
REQ-029 Single retire: push {pc=0x100, we=1, addr=5, data=0xDEADBEEF} into an empty queue -> next cycle rfRdCtrl = {1, 5, 0xDEADBEEF}, rfPc = 0x100.
REQ-030 x0 write: push {we=1, addr=0, data=0x1} -> rfRdCtrl.we = 0 in the drain cycle, queue empties; with the macro, retireCount += 1.
REQ-031 Backpressure: stall = 1, push 0x200 then 0x204 -> memReady = 0 with count = 2; release stall -> writes 0x200 then 0x204 in consecutive cycles, memReady = 1 after the first drain.
REQ-032 Flush: queue holding 2 entries, flush = 1 with a simultaneous offer of 0x300 -> no register file writes afterwards, count = 0, 0x300 never appears on rfPc.
REQ-033 Reset mid-operation: assert rst with count = 2 -> outputs are 0 without waiting for a clock edge; after release memReady = 1 and no stale writes occur.
REQ-034 Streaming: memValid held high for 10 cycles with no stall -> 10 writes in order, one per cycle, count never exceeds 1.
